// File: rtl/tcp_rx_header_parser.sv
// tcp_rx_header_parser
//   Parses the fixed 20-byte TCP header from an IPv4 payload stream, skips
//   options, forwards the segment payload one cycle late, and closes every
//   forwarded frame with exactly one out_commit or out_drop pulse.
//
//   Build option: define TCP_RX_CHECKSUM_EN to compute and check the TCP
//   checksum (pseudo-header included). Without it, a frame that passes the
//   structural checks always commits, with identical timing.
//
//   Ports
//     clk, rst                  clock, async active-high reset
//     in_start                  new IPv4 packet begins
//     in_headers_valid          IPv4 fields below valid (pulse)
//     in_protocol_is_tcp        IPv4 protocol == 6
//     in_payload_len            IPv4 payload length in bytes
//     in_src_ip, in_dst_ip      IPv4 addresses
//     in_data_valid/bytes_valid/data   payload word stream, MSB-first
//     in_commit, in_drop        IPv4 frame ended good/bad
//     out_start                 frame begins
//     out_headers_valid         TCP header outputs valid (pulse)
//     out_src_port..out_window  latched TCP header fields
//     out_src_ip                latched IPv4 source address
//     out_payload_len           TCP payload length in bytes
//     out_data_valid/bytes_valid/data  forwarded payload stream
//     out_commit, out_drop      frame accepted/rejected
module tcp_rx_header_parser (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_start,
   input  logic        in_headers_valid,
   input  logic        in_protocol_is_tcp,
   input  logic [15:0] in_payload_len,
   input  logic [31:0] in_src_ip,
   input  logic [31:0] in_dst_ip,
   input  logic        in_data_valid,
   input  logic [2:0]  in_bytes_valid,
   input  logic [31:0] in_data,
   input  logic        in_commit,
   input  logic        in_drop,
   output logic        out_start,
   output logic        out_headers_valid,
   output logic [15:0] out_src_port,
   output logic [15:0] out_dst_port,
   output logic [31:0] out_seq,
   output logic [31:0] out_ack,
   output logic [8:0]  out_flags,
   output logic [15:0] out_window,
   output logic [31:0] out_src_ip,
   output logic [15:0] out_payload_len,
   output logic        out_data_valid,
   output logic [2:0]  out_bytes_valid,
   output logic [31:0] out_data,
   output logic        out_commit,
   output logic        out_drop
);

   typedef enum logic [3:0] {
      IDLE, WAIT_HDR, HDR0, HDR1, HDR2, HDR3, HDR4, OPTIONS, PAYLOAD, FINISH, ABORT
   } state_t;

   state_t      state;
   logic [15:0] len_q;
   logic [31:0] sip_q;
   logic [15:0] sport_q, dport_q;
   logic [31:0] seq_q, ack_q;
   logic [3:0]  doff_q;
   logic [8:0]  flags_q;
   logic [15:0] win_q;
   logic [3:0]  opt_left;
   logic [15:0] hdr_bytes_in;
   logic [15:0] hdr_bytes_q;
   logic        sum_ok;

   assign hdr_bytes_in = {10'd0, in_data[31:28], 2'b00};
   assign hdr_bytes_q  = {10'd0, doff_q, 2'b00};

`ifdef TCP_RX_CHECKSUM_EN
   logic [31:0] acc;
   logic [31:0] mask;
   logic [31:0] masked;
   logic [31:0] word_sum;
   logic [31:0] pseudo_sum;
   logic [16:0] fold1;
   logic [15:0] fold2;

   // Bytes past in_bytes_valid are zeroed so an odd tail pads correctly.
   always_comb begin
      case (in_bytes_valid)
         3'd1:    mask = 32'hFF00_0000;
         3'd2:    mask = 32'hFFFF_0000;
         3'd3:    mask = 32'hFFFF_FF00;
         default: mask = 32'hFFFF_FFFF;
      endcase
   end

   assign masked     = in_data & mask;
   assign word_sum   = {16'd0, masked[31:16]} + {16'd0, masked[15:0]};
   assign pseudo_sum = {16'd0, in_src_ip[31:16]} + {16'd0, in_src_ip[15:0]}
                     + {16'd0, in_dst_ip[31:16]} + {16'd0, in_dst_ip[15:0]}
                     + 32'd6 + {16'd0, in_payload_len};
   // Two folds suffice: fold1 <= 0x1FFFE, so fold2 never carries out.
   assign fold1  = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
   assign fold2  = fold1[15:0] + {15'd0, fold1[16]};
   assign sum_ok = (fold2 == 16'hFFFF);
`else
   logic unused_dst_ip;
   assign unused_dst_ip = ^in_dst_ip;
   assign sum_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         len_q             <= '0;
         sip_q             <= '0;
         sport_q           <= '0;
         dport_q           <= '0;
         seq_q             <= '0;
         ack_q             <= '0;
         doff_q            <= '0;
         flags_q           <= '0;
         win_q             <= '0;
         opt_left          <= '0;
         out_start         <= 1'b0;
         out_headers_valid <= 1'b0;
         out_src_port      <= '0;
         out_dst_port      <= '0;
         out_seq           <= '0;
         out_ack           <= '0;
         out_flags         <= '0;
         out_window        <= '0;
         out_src_ip        <= '0;
         out_payload_len   <= '0;
         out_data_valid    <= 1'b0;
         out_bytes_valid   <= '0;
         out_data          <= '0;
         out_commit        <= 1'b0;
         out_drop          <= 1'b0;
`ifdef TCP_RX_CHECKSUM_EN
         acc               <= '0;
`endif
      end else begin
         out_start         <= 1'b0;
         out_headers_valid <= 1'b0;
         out_data_valid    <= 1'b0;
         out_commit        <= 1'b0;
         out_drop          <= 1'b0;
         case (state)
            IDLE: begin
               if (in_start) begin
                  state     <= WAIT_HDR;
                  out_start <= 1'b1;
               end
            end
            // acc already holds the final word; fold and decide here.
            FINISH: begin
               out_commit <= sum_ok;
               out_drop   <= !sum_ok;
               state      <= IDLE;
            end
            // out_drop was raised on entry; this cycle just returns home.
            ABORT: state <= IDLE;
            default: begin
               if (in_start || in_drop) begin
                  state <= ABORT; out_drop <= 1'b1;
               end else if (state == WAIT_HDR) begin
                  if (in_commit) begin
                     state <= ABORT; out_drop <= 1'b1;
                  end else if (in_headers_valid) begin
                     if (!in_protocol_is_tcp || in_payload_len < 16'd20) begin
                        state <= ABORT; out_drop <= 1'b1;
                     end else begin
                        len_q <= in_payload_len;
                        sip_q <= in_src_ip;
`ifdef TCP_RX_CHECKSUM_EN
                        acc   <= pseudo_sum;
`endif
                        state <= HDR0;
                     end
                  end
               end else if (state == OPTIONS || state == PAYLOAD) begin
                  if (in_data_valid) begin
`ifdef TCP_RX_CHECKSUM_EN
                     acc <= acc + word_sum;
`endif
                     if (state == PAYLOAD) begin
                        out_data_valid  <= 1'b1;
                        out_data        <= in_data;
                        out_bytes_valid <= in_bytes_valid;
                     end else begin
                        opt_left <= opt_left - 4'd1;
                        if (opt_left == 4'd1) state <= PAYLOAD;
                     end
                  end
                  // A commit alongside the last word still sums it first.
                  if (in_commit) state <= FINISH;
               end else begin
                  // HDR0..HDR4: commit is legal only with the HDR4 word.
                  if (in_commit && (state != HDR4 || !in_data_valid)) begin
                     state <= ABORT; out_drop <= 1'b1;
                  end else if (in_data_valid) begin
                     if (in_bytes_valid != 3'd4) begin
                        state <= ABORT; out_drop <= 1'b1;
                     end else begin
`ifdef TCP_RX_CHECKSUM_EN
                        acc <= acc + word_sum;
`endif
                        case (state)
                           HDR0: begin
                              sport_q <= in_data[31:16];
                              dport_q <= in_data[15:0];
                              state   <= HDR1;
                           end
                           HDR1: begin
                              seq_q <= in_data;
                              state <= HDR2;
                           end
                           HDR2: begin
                              ack_q <= in_data;
                              state <= HDR3;
                           end
                           HDR3: begin
                              if (in_data[31:28] < 4'd5 || hdr_bytes_in > len_q) begin
                                 state <= ABORT; out_drop <= 1'b1;
                              end else begin
                                 doff_q  <= in_data[31:28];
                                 flags_q <= in_data[24:16];
                                 win_q   <= in_data[15:0];
                                 state   <= HDR4;
                              end
                           end
                           default: begin
                              out_headers_valid <= 1'b1;
                              out_src_port      <= sport_q;
                              out_dst_port      <= dport_q;
                              out_seq           <= seq_q;
                              out_ack           <= ack_q;
                              out_flags         <= flags_q;
                              out_window        <= win_q;
                              out_src_ip        <= sip_q;
                              out_payload_len   <= len_q - hdr_bytes_q;
                              opt_left          <= doff_q - 4'd5;
                              if (in_commit)            state <= FINISH;
                              else if (doff_q > 4'd5)   state <= OPTIONS;
                              else                      state <= PAYLOAD;
                           end
                        endcase
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tcp_rx_header_parser.sv
// Scoreboard bench for tcp_rx_header_parser. Tasks push expected events,
// a negedge monitor records observed events, and each test task pops and
// compares them inline.
module tb_tcp_rx_header_parser;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_start, in_headers_valid, in_protocol_is_tcp;
   logic [15:0] in_payload_len;
   logic [31:0] in_src_ip, in_dst_ip;
   logic        in_data_valid;
   logic [2:0]  in_bytes_valid;
   logic [31:0] in_data;
   logic        in_commit, in_drop;
   logic        out_start, out_headers_valid;
   logic [15:0] out_src_port, out_dst_port;
   logic [31:0] out_seq, out_ack;
   logic [8:0]  out_flags;
   logic [15:0] out_window;
   logic [31:0] out_src_ip;
   logic [15:0] out_payload_len;
   logic        out_data_valid;
   logic [2:0]  out_bytes_valid;
   logic [31:0] out_data;
   logic        out_commit, out_drop;

   tcp_rx_header_parser dut (
      .clk(clk), .rst(rst),
      .in_start(in_start), .in_headers_valid(in_headers_valid),
      .in_protocol_is_tcp(in_protocol_is_tcp), .in_payload_len(in_payload_len),
      .in_src_ip(in_src_ip), .in_dst_ip(in_dst_ip),
      .in_data_valid(in_data_valid), .in_bytes_valid(in_bytes_valid), .in_data(in_data),
      .in_commit(in_commit), .in_drop(in_drop),
      .out_start(out_start), .out_headers_valid(out_headers_valid),
      .out_src_port(out_src_port), .out_dst_port(out_dst_port),
      .out_seq(out_seq), .out_ack(out_ack), .out_flags(out_flags),
      .out_window(out_window), .out_src_ip(out_src_ip),
      .out_payload_len(out_payload_len),
      .out_data_valid(out_data_valid), .out_bytes_valid(out_bytes_valid),
      .out_data(out_data), .out_commit(out_commit), .out_drop(out_drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   wire [208:0] all_out = {out_start, out_headers_valid, out_src_port, out_dst_port,
                           out_seq, out_ack, out_flags, out_window, out_src_ip,
                           out_payload_len, out_data_valid, out_bytes_valid,
                           out_data, out_commit, out_drop};

   typedef struct packed {
      logic [15:0] sp;
      logic [15:0] dp;
      logic [31:0] seq;
      logic [31:0] ack;
      logic [8:0]  fl;
      logic [15:0] win;
      logic [31:0] sip;
      logic [15:0] plen;
   } hdr_t;

   typedef struct packed {
      logic        commit;
      logic [31:0] cyc;
   } end_t;

   hdr_t        obs_hdr[$], exp_hdr[$];
   end_t        obs_end[$], exp_end[$];
   logic [34:0] obs_data[$], exp_data[$];
   int          n_start;
   int          total = 0;
   int          bad = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (out_start) n_start++;
         if (out_headers_valid)
            obs_hdr.push_back('{out_src_port, out_dst_port, out_seq, out_ack,
                                out_flags, out_window, out_src_ip, out_payload_len});
         if (out_data_valid) obs_data.push_back({out_bytes_valid, out_data});
         if (out_commit) obs_end.push_back('{1'b1, cyc});
         if (out_drop)   obs_end.push_back('{1'b0, cyc});
      end
   end

   // Packet under construction
   logic [31:0] pkt_w[$];
   logic [2:0]  pkt_bv[$];
   logic [15:0] pkt_len;
   logic [31:0] pk_sip = 32'h0A00_0001;
   logic [31:0] pk_dip = 32'h0A00_0002;

   task automatic step();
      @(posedge clk);
      #1;
      in_start = 1'b0; in_headers_valid = 1'b0; in_data_valid = 1'b0;
      in_commit = 1'b0; in_drop = 1'b0; in_bytes_valid = 3'd0; in_data = '0;
   endtask

   task automatic clear_sb();
      obs_hdr.delete(); exp_hdr.delete(); obs_end.delete(); exp_end.delete();
      obs_data.delete(); exp_data.delete(); n_start = 0;
   endtask

   task automatic build_pkt(input logic [15:0] sport, input logic [15:0] dport,
                            input logic [31:0] seq, input logic [31:0] ack,
                            input int doff, input logic [8:0] flags,
                            input logic [15:0] win, input int npay, input bit corrupt);
      logic [31:0] s;
      logic [31:0] w;
      logic [15:0] cs;
      logic [3:0]  d4;
      int nb;
      d4 = 4'(doff);
      pkt_w.delete(); pkt_bv.delete();
      pkt_len = 16'(4 * doff + npay);
      pkt_w.push_back({sport, dport});
      pkt_w.push_back(seq);
      pkt_w.push_back(ack);
      pkt_w.push_back({d4, 3'b000, flags, win});
      pkt_w.push_back(32'h0);
      for (int i = 0; i < doff - 5; i++) pkt_w.push_back(32'h0101_0101 + i);
      repeat (pkt_w.size()) pkt_bv.push_back(3'd4);
      for (int i = 0; i < npay; i += 4) begin
         w = '0;
         nb = (npay - i < 4) ? npay - i : 4;
         for (int j = 0; j < nb; j++) w[31 - 8*j -: 8] = 8'(8'hA0 + i + j);
         pkt_w.push_back(w);
         pkt_bv.push_back(3'(nb));
      end
      s = {16'd0, pk_sip[31:16]} + {16'd0, pk_sip[15:0]} + {16'd0, pk_dip[31:16]}
        + {16'd0, pk_dip[15:0]} + 32'd6 + {16'd0, pkt_len};
      foreach (pkt_w[i]) s = s + {16'd0, pkt_w[i][31:16]} + {16'd0, pkt_w[i][15:0]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      cs = ~s[15:0];
      if (corrupt) cs = cs ^ 16'h0100;
      pkt_w[4] = {cs, 16'h0000};
   endtask

   // stop_kind: 0 none, 1 in_drop in place of word stop_at, 2 rst there.
   task automatic send_pkt(input logic proto, input logic [15:0] len,
                           input int stop_at, input int stop_kind,
                           output int hv_cyc, output int last_cyc);
      in_start = 1'b1; step();
      in_headers_valid = 1'b1; in_protocol_is_tcp = proto; in_payload_len = len;
      in_src_ip = pk_sip; in_dst_ip = pk_dip; hv_cyc = cyc; step();
      last_cyc = cyc;
      for (int i = 0; i < pkt_w.size(); i++) begin
         if (i == stop_at) begin
            last_cyc = cyc;
            if (stop_kind == 1) begin
               in_drop = 1'b1; step();
            end else begin
               rst = 1'b1;
            end
            return;
         end
         in_data_valid = 1'b1; in_data = pkt_w[i]; in_bytes_valid = pkt_bv[i];
         in_commit = (i == pkt_w.size() - 1); last_cyc = cyc; step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_protocol_is_tcp = 1'b0; in_payload_len = '0; in_src_ip = '0; in_dst_ip = '0;
      in_start = 1'b0; in_headers_valid = 1'b0; in_data_valid = 1'b0;
      in_bytes_valid = '0; in_data = '0; in_commit = 1'b0; in_drop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (all_out !== '0) begin bad++; $display("FAIL reset_hold: got %h want 0", all_out); end
      rst = 1'b0;
      step(); step();
      total++;
      if (all_out !== '0) begin bad++; $display("FAIL reset_idle: got %h want 0", all_out); end
   endtask

   task automatic test_syn();
      int hv, lc;
      hdr_t h, e;
      end_t eo, ee;
      clear_sb();
      build_pkt(16'd1234, 16'd80, 32'h1122_3344, 32'h0, 5, 9'h002, 16'hFFFF, 0, 1'b0);
      exp_hdr.push_back('{16'd1234, 16'd80, 32'h1122_3344, 32'h0, 9'h002, 16'hFFFF, pk_sip, 16'd0});
      send_pkt(1'b1, pkt_len, -1, 0, hv, lc);
      exp_end.push_back('{1'b1, 32'(lc + 2)});
      repeat (5) step();
      total++;
      if (n_start !== 1) begin bad++; $display("FAIL syn_start_count: got %0d want 1", n_start); end
      total++;
      if (obs_hdr.size() !== 1) begin bad++; $display("FAIL syn_hdr_count: got %0d want 1", obs_hdr.size()); end
      if (obs_hdr.size() > 0) begin
         h = obs_hdr.pop_front(); e = exp_hdr.pop_front();
         total++;
         if (h !== e) begin bad++; $display("FAIL syn_hdr_fields: got %h want %h", h, e); end
      end
      total++;
      if (obs_end.size() !== 1) begin bad++; $display("FAIL syn_end_count: got %0d want 1", obs_end.size()); end
      if (obs_end.size() > 0) begin
         eo = obs_end.pop_front(); ee = exp_end.pop_front();
         total++;
         if (eo !== ee) begin bad++; $display("FAIL syn_commit: got commit=%0b cyc=%0d want commit=%0b cyc=%0d", eo.commit, eo.cyc, ee.commit, ee.cyc); end
      end
   endtask

   task automatic test_bad_checksum();
      int hv, lc;
      end_t eo, ee;
      logic want_commit;
`ifdef TCP_RX_CHECKSUM_EN
      want_commit = 1'b0;
`else
      want_commit = 1'b1;
`endif
      clear_sb();
      build_pkt(16'd1234, 16'd80, 32'h1122_3344, 32'h0, 5, 9'h002, 16'hFFFF, 0, 1'b1);
      send_pkt(1'b1, pkt_len, -1, 0, hv, lc);
      exp_end.push_back('{want_commit, 32'(lc + 2)});
      repeat (5) step();
      total++;
      if (obs_end.size() !== 1) begin bad++; $display("FAIL badcs_end_count: got %0d want 1", obs_end.size()); end
      if (obs_end.size() > 0) begin
         eo = obs_end.pop_front(); ee = exp_end.pop_front();
         total++;
         if (eo !== ee) begin bad++; $display("FAIL badcs_result: got commit=%0b cyc=%0d want commit=%0b cyc=%0d", eo.commit, eo.cyc, ee.commit, ee.cyc); end
      end
   endtask

   task automatic test_options();
      int hv, lc;
      hdr_t h, e;
      end_t eo, ee;
      logic [34:0] dobs, dexp;
      clear_sb();
      build_pkt(16'd5000, 16'd443, 32'hDEAD_BEEF, 32'h0102_0304, 8, 9'h018, 16'h2000, 5, 1'b0);
      exp_hdr.push_back('{16'd5000, 16'd443, 32'hDEAD_BEEF, 32'h0102_0304, 9'h018, 16'h2000, pk_sip, 16'd5});
      for (int i = 8; i < pkt_w.size(); i++) exp_data.push_back({pkt_bv[i], pkt_w[i]});
      send_pkt(1'b1, pkt_len, -1, 0, hv, lc);
      exp_end.push_back('{1'b1, 32'(lc + 2)});
      repeat (5) step();
      total++;
      if (obs_hdr.size() !== 1) begin bad++; $display("FAIL opt_hdr_count: got %0d want 1", obs_hdr.size()); end
      if (obs_hdr.size() > 0) begin
         h = obs_hdr.pop_front(); e = exp_hdr.pop_front();
         total++;
         if (h !== e) begin bad++; $display("FAIL opt_hdr_fields: got %h want %h", h, e); end
      end
      total++;
      if (obs_data.size() !== 2) begin bad++; $display("FAIL opt_data_count: got %0d want 2", obs_data.size()); end
      while (obs_data.size() > 0 && exp_data.size() > 0) begin
         dobs = obs_data.pop_front(); dexp = exp_data.pop_front();
         total++;
         if (dobs !== dexp) begin bad++; $display("FAIL opt_data_word: got %h want %h", dobs, dexp); end
      end
      if (obs_end.size() > 0) begin
         eo = obs_end.pop_front(); ee = exp_end.pop_front();
         total++;
         if (eo !== ee) begin bad++; $display("FAIL opt_commit: got commit=%0b cyc=%0d want commit=%0b cyc=%0d", eo.commit, eo.cyc, ee.commit, ee.cyc); end
      end else begin
         total++; bad++; $display("FAIL opt_commit: got no end event want commit");
      end
   endtask

   task automatic test_rejects();
      int hv, lc;
      end_t eo, ee;
      logic proto;
      logic [15:0] len;
      for (int k = 0; k < 3; k++) begin
         clear_sb();
         if (k == 2) build_pkt(16'd7, 16'd8, 32'h5, 32'h6, 4, 9'h010, 16'h100, 4, 1'b0);
         else        build_pkt(16'd7, 16'd8, 32'h5, 32'h6, 5, 9'h010, 16'h100, 4, 1'b0);
         proto = (k != 0);
         len   = (k == 1) ? 16'd16 : pkt_len;
         send_pkt(proto, len, -1, 0, hv, lc);
         exp_end.push_back('{1'b0, 32'((k == 2) ? hv + 5 : hv + 1)});
         repeat (4) step();
         total++;
         if (obs_hdr.size() !== 0) begin bad++; $display("FAIL reject%0d_hdr: got %0d headers want 0", k, obs_hdr.size()); end
         total++;
         if (obs_end.size() !== 1) begin bad++; $display("FAIL reject%0d_end_count: got %0d want 1", k, obs_end.size()); end
         if (obs_end.size() > 0) begin
            eo = obs_end.pop_front(); ee = exp_end.pop_front();
            total++;
            if (eo !== ee) begin bad++; $display("FAIL reject%0d_drop: got commit=%0b cyc=%0d want commit=%0b cyc=%0d", k, eo.commit, eo.cyc, ee.commit, ee.cyc); end
         end
      end
   endtask

   task automatic test_drop_mid();
      int hv, lc;
      end_t eo, ee;
      clear_sb();
      build_pkt(16'd1111, 16'd2222, 32'h10, 32'h20, 5, 9'h018, 16'h400, 20, 1'b0);
      send_pkt(1'b1, pkt_len, 7, 1, hv, lc);
      exp_end.push_back('{1'b0, 32'(lc + 1)});
      repeat (4) step();
      total++;
      if (obs_data.size() !== 2) begin bad++; $display("FAIL dropmid_data_count: got %0d want 2", obs_data.size()); end
      total++;
      if (obs_end.size() !== 1) begin bad++; $display("FAIL dropmid_end_count: got %0d want 1", obs_end.size()); end
      if (obs_end.size() > 0) begin
         eo = obs_end.pop_front(); ee = exp_end.pop_front();
         total++;
         if (eo !== ee) begin bad++; $display("FAIL dropmid_drop: got commit=%0b cyc=%0d want commit=%0b cyc=%0d", eo.commit, eo.cyc, ee.commit, ee.cyc); end
      end
      clear_sb();
      build_pkt(16'd1234, 16'd80, 32'h1122_3344, 32'h0, 5, 9'h002, 16'hFFFF, 0, 1'b0);
      send_pkt(1'b1, pkt_len, -1, 0, hv, lc);
      exp_end.push_back('{1'b1, 32'(lc + 2)});
      repeat (5) step();
      total++;
      if (obs_end.size() !== 1 || obs_end[0] !== exp_end[0])
         begin bad++; $display("FAIL dropmid_next_commit: got %0d events first=%h want 1 event %h", obs_end.size(), (obs_end.size() > 0) ? obs_end[0] : '0, exp_end[0]); end
   endtask

   task automatic test_reset_mid();
      int hv, lc;
      clear_sb();
      build_pkt(16'd4321, 16'd25, 32'hCAFE_0001, 32'h0, 5, 9'h010, 16'h800, 8, 1'b0);
      send_pkt(1'b1, pkt_len, 2, 2, hv, lc);
      #1;
      total++;
      if (all_out !== '0) begin bad++; $display("FAIL rstmid_outputs: got %h want 0", all_out); end
      step();
      rst = 1'b0;
      repeat (4) step();
      total++;
      if (obs_end.size() !== 0) begin bad++; $display("FAIL rstmid_no_end: got %0d events want 0", obs_end.size()); end
      clear_sb();
      build_pkt(16'd1234, 16'd80, 32'h1122_3344, 32'h0, 5, 9'h002, 16'hFFFF, 4, 1'b0);
      send_pkt(1'b1, pkt_len, -1, 0, hv, lc);
      exp_end.push_back('{1'b1, 32'(lc + 2)});
      repeat (5) step();
      total++;
      if (obs_end.size() !== 1 || obs_end[0] !== exp_end[0])
         begin bad++; $display("FAIL rstmid_next_commit: got %0d events first=%h want 1 event %h", obs_end.size(), (obs_end.size() > 0) ? obs_end[0] : '0, exp_end[0]); end
   endtask

   initial begin
      test_reset();
      test_syn();
      test_bad_checksum();
      test_options();
      test_rejects();
      test_drop_mid();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

endmodule
